fp_accumulator: RTL and testbench

- Sequential floating-point accumulator that sits directly downstream of floating_point_mul in the convolution / fully-connected datapath.
- Consumes a stream of products and sums them into an internal running total. On the element flagged last, it presents the total as one result word.
- Uses the same IEEE-style packing as the multiplier: sign | exponent | mantissa, hidden leading 1, no denormals, truncation instead of rounding.
- It is a multi-cycle adder FSM, one operand at a time, with valid/ready handshakes on input and output.

---
 rtl/fp_accumulator.sv | 163 ++++++++++++++++
 tb/tb_fp_accumulator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accumulator.sv
// fp_accumulator
//   Sequential floating-point accumulator placed after floating_point_mul.
//   Sums a stream of operands into a running total and presents the total
//   when the operand flagged last has been added. Format is sign|exp|mant
//   with a hidden leading 1, no denormals and truncation instead of rounding.
//   Each operand takes IDLE -> ALIGN -> ADD -> NORM (4 cycles).
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   product_in          operand to add
//   in_valid, in_last   operand valid / operand closes the current sum
//   in_ready            operand can be accepted (only in IDLE)
//   sum_out, out_valid  completed sum, held while out_valid is high
//   out_ready           consumer accepts sum_out
module fp_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] product_in,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BIAS = 2**(E-1) - 1;
  localparam int MW   = M + 2;
  localparam int LZW  = $clog2(M + 2);
  localparam logic [E-1:0] EXP_SAT  = E'(2 * BIAS);
  localparam logic [E-1:0] SH_LIMIT = E'(M + 2);
  localparam logic [E+1:0] EXP_ONES = (E+2)'(2**E - 1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;
  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] acc, b_reg, sum_reg;
  logic                  last_flag, out_valid_reg;
  logic                  x_sign, op_sub;
  logic [E-1:0]          x_exp;
  logic [MW-1:0]         x_mant, y_mant, sum_mant;

  // Alignment: larger magnitude becomes X. Comparing the exponent|mantissa
  // bits as one unsigned number orders by exponent first, then mantissa.
  logic                  swap;
  logic [DATA_WIDTH-1:0] xw, yw;
  logic [E-1:0]          exp_diff;
  logic [MW-1:0]         xm_c, ym_c, ym_sh;

  always_comb begin
    swap     = b_reg[DATA_WIDTH-2:0] > acc[DATA_WIDTH-2:0];
    xw       = swap ? b_reg : acc;
    yw       = swap ? acc : b_reg;
    xm_c     = (xw[DATA_WIDTH-2:0] == '0) ? '0 : {2'b01, xw[M-1:0]};
    ym_c     = (yw[DATA_WIDTH-2:0] == '0) ? '0 : {2'b01, yw[M-1:0]};
    exp_diff = xw[DATA_WIDTH-2:M] - yw[DATA_WIDTH-2:M];
    ym_sh    = (exp_diff >= SH_LIMIT) ? '0 : (ym_c >> exp_diff);
  end

  // Normalisation: carry -> shift right once; otherwise single-cycle left
  // shift by the leading-zero count of bits [M:0].
  logic [LZW-1:0]        lz;
  logic                  found;
  logic [M-1:0]          norm_frac;
  logic [E+1:0]          new_exp;
  logic [DATA_WIDTH-1:0] result;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i <= M; i++) begin
      if (!found && sum_mant[M-i]) begin
        lz    = LZW'(i);
        found = 1'b1;
      end
    end

    if (sum_mant[MW-1]) begin
      norm_frac = sum_mant[M:1];
      new_exp   = {2'b00, x_exp} + (E+2)'(1);
    end else begin
      norm_frac = M'(sum_mant << lz);
      new_exp   = {2'b00, x_exp} - (E+2)'(lz);
    end

    if (sum_mant == '0)
      result = '0;
    else if (!sum_mant[MW-1] && ({2'b00, x_exp} <= (E+2)'(lz)))
      result = '0;
    else if (new_exp >= EXP_ONES)
      result = {x_sign, EXP_SAT, {M{1'b1}}};
    else
      result = {x_sign, new_exp[E-1:0], norm_frac};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = last_flag ? OUT : IDLE;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      last_flag     <= 1'b0;
      out_valid_reg <= 1'b0;
      x_sign        <= 1'b0;
      op_sub        <= 1'b0;
      x_exp         <= '0;
      x_mant        <= '0;
      y_mant        <= '0;
      sum_mant      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          b_reg     <= product_in;
          last_flag <= in_last;
        end
        ALIGN: begin
          x_sign <= xw[DATA_WIDTH-1];
          x_exp  <= xw[DATA_WIDTH-2:M];
          x_mant <= xm_c;
          y_mant <= ym_sh;
          op_sub <= xw[DATA_WIDTH-1] ^ yw[DATA_WIDTH-1];
        end
        ADD: sum_mant <= op_sub ? (x_mant - y_mant) : (x_mant + y_mant);
        NORM: begin
          acc <= result;
          if (last_flag) begin
            sum_reg       <= result;
            out_valid_reg <= 1'b1;
          end
        end
        OUT: if (out_ready) begin
          acc           <= '0;
          out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_reg;
  assign sum_out   = sum_reg;

endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator
//   Self-checking bench for fp_accumulator (32-bit format). Directed sums,
//   backpressure, asynchronous reset, handshake gating and randomized sums
//   checked against a behavioural floating-point reference model.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] product_in;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] sum_out;
  logic        out_valid;
  logic        out_ready;

  fp_accumulator #(.DATA_WIDTH(32), .E(8), .M(23)) dut (
    .clk        (clk),
    .reset      (reset),
    .product_in (product_in),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .sum_out    (sum_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hs_count = 0;
  int sent  = 0;
  logic [31:0] model_acc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: exact integer arithmetic on decoded operands, truncating
  // alignment, normalise by repeated shifting, flush/saturate at the ends.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    longint xm, ym, s;
    int e, d;
    if (b[30:0] > a[30:0]) begin x = b; y = a; end
    else                   begin x = a; y = b; end
    xm = (x[30:0] == 0) ? 0 : (64'h800000 | longint'(x[22:0]));
    ym = (y[30:0] == 0) ? 0 : (64'h800000 | longint'(y[22:0]));
    d  = int'(x[30:23]) - int'(y[30:23]);
    ym = (d >= 25) ? 0 : (ym >> d);
    s  = (x[31] == y[31]) ? xm + ym : xm - ym;
    if (s == 0) return 32'h0;
    e = int'(x[30:23]);
    while (s >= 64'h1000000) begin s = s >> 1; e++; end
    while (s <  64'h800000)  begin s = s << 1; e--; end
    if (e <= 0)   return 32'h0;
    if (e >= 255) return {x[31], 8'hFE, 23'h7FFFFF};
    return {x[31], e[7:0], s[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = {$urandom_range(0, 1) == 1, 8'($urandom_range(112, 140)), 23'($urandom)};
    if ($urandom_range(0, 7) == 0) v = 32'h0;
    return v;
  endfunction

  always @(negedge clk)
    if (!reset && in_valid && in_ready) hs_count++;

  task automatic send_op(input logic [31:0] d, input logic last);
    product_in = d;
    in_last    = last;
    in_valid   = 1'b1;
    for (int n = 0; n < 50 && !in_ready; n++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check_val("ready_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    sent++;
    model_acc = ref_add(model_acc, d);
  endtask

  task automatic get_sum(input string tag, input logic [31:0] want);
    for (int n = 0; n < 50 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    check_val({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check_val(tag, sum_out, want);
    @(posedge clk); #1;
    model_acc = 32'h0;
  endtask

  task automatic do_sum(input string tag, input int n, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [31:0] want);
    send_op(a, n == 1);
    if (n >= 2) send_op(b, n == 2);
    if (n >= 3) send_op(c, 1'b1);
    get_sum(tag, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r [12];
    logic [31:0] held;
    logic [31:0] v;
    int nops;

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; product_in = '0;
    out_ready = 1'b1; model_acc = 32'h0;
    #1;
    check_val("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_sum_out",   sum_out,            32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic sum with latency check on the last operand
    send_op(32'h3F800000, 1'b0);
    send_op(32'h40000000, 1'b0);
    send_op(32'h40400000, 1'b1);
    check_val("lat_align_ready", {31'b0, in_ready},  32'd0);
    check_val("lat_align_ov",    {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_val("lat_add_ov",      {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_val("lat_norm_ov",     {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check_val("lat_out_ov",      {31'b0, out_valid}, 32'd1);
    get_sum("basic_sum", 32'h40C00000);

    // Normalisation paths, cancellation, zero, saturation, flush
    do_sum("norm_carry",   2, 32'h3FC00000, 32'h3FC00000, 0, 32'h40400000);
    do_sum("norm_noshift", 2, 32'h40400000, 32'hBF000000, 0, 32'h40200000);
    do_sum("norm_lshift",  2, 32'h3F800000, 32'hBF400000, 0, 32'h3E800000);
    do_sum("cancel",       2, 32'h3F800000, 32'hBF800000, 0, 32'h00000000);
    do_sum("single_zero",  1, 32'h00000000, 0, 0, 32'h00000000);
    do_sum("single_half",  1, 32'h3F000000, 0, 0, 32'h3F000000);
    do_sum("x_plus_zero",  3, 32'hC1234567, 32'h00000000, 32'h80000000, 32'hC1234567);
    do_sum("sat_pos",      2, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F7FFFFF);
    do_sum("sat_neg",      2, 32'hFF7FFFFF, 32'hFF7FFFFF, 0, 32'hFF7FFFFF);
    do_sum("flush",        2, 32'h00800000, 32'h80C00000, 0, 32'h00000000);
    do_sum("far_shift",    2, 32'h4B800000, 32'h3F800000, 0, 32'h4B800000);

    // Backpressure: outputs frozen while out_ready is low
    out_ready = 1'b0;
    send_op(32'h3F800000, 1'b0);
    send_op(32'h3F800000, 1'b1);
    for (int n = 0; n < 50 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      product_in = $urandom;
      in_valid   = 1'b1;
      check_val("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check_val("bp_sum_out",   sum_out,            32'h40000000);
      check_val("bp_in_ready",  {31'b0, in_ready},  32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_ready_after", {31'b0, in_ready},  32'd1);
    check_val("bp_ov_after",    {31'b0, out_valid}, 32'd0);
    model_acc = 32'h0;
    do_sum("after_bp", 1, 32'h40000000, 0, 0, 32'h40000000);

    // Asynchronous reset during ADD of the second operand
    send_op(32'h3F800000, 1'b0);
    send_op(32'h40000000, 1'b1);
    @(posedge clk); #1;
    #1 reset = 1'b1;
    #1;
    check_val("arst_in_ready",  {31'b0, in_ready},  32'd1);
    check_val("arst_out_valid", {31'b0, out_valid}, 32'd0);
    #1 reset = 1'b0;
    model_acc = 32'h0;
    @(posedge clk); #1;
    do_sum("after_rst", 1, 32'h3F800000, 0, 0, 32'h3F800000);

    // Handshake gating: in_valid held high with fresh data every cycle;
    // starting in IDLE only cycles 0, 4 and 8 are IDLE cycles.
    for (int k = 0; k < 12; k++) begin
      r[k]       = rand_fp();
      product_in = r[k];
      in_valid   = 1'b1;
      in_last    = 1'b0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    model_acc = ref_add(ref_add(ref_add(32'h0, r[0]), r[4]), r[8]);
    sent += 3;
    held = rand_fp();
    send_op(held, 1'b1);
    get_sum("gating_sum", model_acc == 32'h0 ? 32'h0 : model_acc);

    // Randomized sums against the reference model
    for (int s = 0; s < 25; s++) begin
      nops = $urandom_range(1, 5);
      v = 32'h0;
      for (int k = 0; k < nops; k++) begin
        logic [31:0] op;
        op = rand_fp();
        if (k > 0 && $urandom_range(0, 5) == 0) op = {~v[31], v[30:0]};
        v = op;
        send_op(op, k == nops - 1);
      end
      get_sum("rand_sum", model_acc);
    end

    check_val("accept_count", 32'(hs_count), 32'(sent));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
